mestre_banco_regs: RTL and testbench

Initiator-side controller for the 4×8-bit register bank (`BancoRegis`). It accepts read/write commands over a valid/ready handshake and drives the bank's write port (`EscreveReg`, `regEscrito`, `dadoEscrito`) and one read port. It returns each result on a valid/ready response channel. After reset it clears every bank register before accepting commands. It sits between the test/debug loader or control unit and the register bank.

---
 rtl/mestre_banco_regs_pkg.sv | 20 ++
 rtl/contador_inicializacao.sv | 36 +++
 rtl/mestre_banco_regs.sv | 190 +++++++++++++++++++
 tb/tb_mestre_banco_regs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mestre_banco_regs_pkg.sv
// Shared types and defaults for the register-bank initiator (mestre_banco_regs).
// Optional read-back verification is enabled by defining READBACK_CHECK_EN.
package mestre_banco_regs_pkg;

  localparam int unsigned LARGURA_DADO_PADRAO = 8;
  localparam int unsigned LARGURA_END_PADRAO  = 2;

  localparam logic CMD_LEITURA = 1'b0;
  localparam logic CMD_ESCRITA = 1'b1;

  typedef enum logic [2:0] {
    EST_INIT,
    EST_IDLE,
    EST_WRITE,
    EST_VERIFY,
    EST_READ,
    EST_RESP
  } estado_t;

endpackage

// File: rtl/contador_inicializacao.sv
// Saturating address counter that walks the bank during the post-reset clear.
module contador_inicializacao
  import mestre_banco_regs_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_END_PADRAO
) (
  input  logic               clock,
  input  logic               clr,
  input  logic               inc,
  output logic [LARGURA-1:0] cnt,
  output logic               tc
);

  localparam logic [LARGURA-1:0] CNT_MAX = '1;

  logic [LARGURA-1:0] cnt_q;
  logic [LARGURA-1:0] cnt_d;

  // Holds at the last address instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clock) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mestre_banco_regs.sv
// Initiator for the 4x8 register bank: clears it after reset, then serves
// read/write commands. Define READBACK_CHECK_EN to add write read-back checking.
module mestre_banco_regs
  import mestre_banco_regs_pkg::*;
#(
  parameter int unsigned              LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int unsigned              LARGURA_END  = LARGURA_END_PADRAO,
  parameter logic [LARGURA_DADO-1:0] VALOR_INIT   = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [LARGURA_END-1:0]  cmd_addr,
  input  logic [LARGURA_DADO-1:0] cmd_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [LARGURA_DADO-1:0] resp_data,
  output logic                    resp_erro,
  output logic                    busy,
  output logic                    EscreveReg,
  output logic [LARGURA_END-1:0]  regEscrito,
  output logic [LARGURA_DADO-1:0] dadoEscrito,
  output logic [LARGURA_END-1:0]  regLido,
  input  logic [LARGURA_DADO-1:0] dadoLido
);

  estado_t                 state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [LARGURA_DADO-1:0] resp_data_q, resp_data_d;
  logic                    busy_q, busy_d;
  logic                    escreve_q, escreve_d;
  logic [LARGURA_END-1:0]  reg_escrito_q, reg_escrito_d;
  logic [LARGURA_DADO-1:0] dado_escrito_q, dado_escrito_d;
  logic [LARGURA_END-1:0]  reg_lido_q, reg_lido_d;
`ifdef READBACK_CHECK_EN
  logic                    resp_erro_q, resp_erro_d;
`endif

  logic                    cnt_inc;
  logic [LARGURA_END-1:0]  cnt_init;
  logic                    cnt_tc;

  contador_inicializacao #(
    .LARGURA (LARGURA_END)
  ) u_contador (
    .clock (clock),
    .clr   (reset),
    .inc   (cnt_inc),
    .cnt   (cnt_init),
    .tc    (cnt_tc)
  );

  // Every output register is loaded with the value for the state being entered,
  // so the write address/data registers also serve as the latched command.
  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = 1'b0;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    escreve_d      = 1'b0;
    reg_escrito_d  = reg_escrito_q;
    dado_escrito_d = dado_escrito_q;
    reg_lido_d     = reg_lido_q;
`ifdef READBACK_CHECK_EN
    resp_erro_d    = resp_erro_q;
`endif
    cnt_inc        = 1'b0;

    case (state_q)
      EST_INIT: begin
        escreve_d      = 1'b1;
        reg_escrito_d  = cnt_init;
        dado_escrito_d = VALOR_INIT;
        cnt_inc        = 1'b1;
        if (cnt_tc) begin
          state_d = EST_IDLE;
        end
      end

      EST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_write == CMD_ESCRITA) begin
            state_d        = EST_WRITE;
            escreve_d      = 1'b1;
            reg_escrito_d  = cmd_addr;
            dado_escrito_d = cmd_data;
          end else begin
            state_d    = EST_READ;
            reg_lido_d = cmd_addr;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      EST_WRITE: begin
`ifdef READBACK_CHECK_EN
        state_d    = EST_VERIFY;
        reg_lido_d = reg_escrito_q;
`else
        state_d      = EST_RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = dado_escrito_q;
`endif
      end

`ifdef READBACK_CHECK_EN
      EST_VERIFY: begin
        state_d      = EST_RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = dadoLido;
        resp_erro_d  = (dadoLido != dado_escrito_q);
      end
`endif

      EST_READ: begin
        state_d      = EST_RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = dadoLido;
`ifdef READBACK_CHECK_EN
        resp_erro_d  = 1'b0;
`endif
      end

      EST_RESP: begin
        if (resp_ready) begin
          state_d     = EST_IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = EST_INIT;
      end
    endcase

    busy_d = (state_d != EST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= EST_INIT;
      cmd_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      busy_q         <= 1'b1;
      escreve_q      <= 1'b0;
      reg_escrito_q  <= '0;
      dado_escrito_q <= '0;
      reg_lido_q     <= '0;
`ifdef READBACK_CHECK_EN
      resp_erro_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      busy_q         <= busy_d;
      escreve_q      <= escreve_d;
      reg_escrito_q  <= reg_escrito_d;
      dado_escrito_q <= dado_escrito_d;
      reg_lido_q     <= reg_lido_d;
`ifdef READBACK_CHECK_EN
      resp_erro_q    <= resp_erro_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign busy        = busy_q;
  // A reset arriving mid-write must keep that write out of the bank
  assign EscreveReg  = escreve_q & ~reset;
  assign regEscrito  = reg_escrito_q;
  assign dadoEscrito = dado_escrito_q;
  assign regLido     = reg_lido_q;
`ifdef READBACK_CHECK_EN
  assign resp_erro   = resp_erro_q;
`else
  assign resp_erro   = 1'b0;
`endif

endmodule

// File: tb/tb_mestre_banco_regs.sv
// Directed bench for mestre_banco_regs with a behavioural 4x8 register bank.
module tb_mestre_banco_regs;

`ifdef READBACK_CHECK_EN
  localparam int LAT_ESC = 2;
`else
  localparam int LAT_ESC = 1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_data;
  logic       resp_erro, busy;
  logic       EscreveReg;
  logic [1:0] regEscrito, regLido;
  logic [7:0] dadoEscrito, dadoLido;

  logic [7:0] banco [4] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5};
  logic       forcar_zero = 1'b0;
  int         n_pulsos = 0;
  logic       escreveu_7_em_0 = 1'b0;
  int         n_total = 0;
  int         n_pass = 0;

  always #5 clock = ~clock;

  mestre_banco_regs dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_erro   (resp_erro),
    .busy        (busy),
    .EscreveReg  (EscreveReg),
    .regEscrito  (regEscrito),
    .dadoEscrito (dadoEscrito),
    .regLido     (regLido),
    .dadoLido    (dadoLido)
  );

  // Bank model plus write monitor
  always @(posedge clock) begin
    if (EscreveReg === 1'b1) begin
      banco[regEscrito] <= dadoEscrito;
      n_pulsos <= n_pulsos + 1;
      if (regEscrito == 2'd0 && dadoEscrito == 8'd7) escreveu_7_em_0 <= 1'b1;
    end
  end

  always_comb dadoLido = (forcar_zero && regLido == 2'd2) ? 8'd0 : banco[regLido];

  task automatic do_cmd(input logic w, input logic [1:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int lat,
                        output logic rdy_apos);
    int espera;
    espera = 0;
    while (cmd_ready !== 1'b1 && espera < 50) begin
      @(negedge clock);
      espera++;
    end
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_wait: cmd_ready=%b want 1", cmd_ready);
    else n_pass++;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
    @(negedge clock);
    cmd_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = resp_data;
    er = resp_erro;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    rdy_apos = cmd_ready;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_total++;
    if ({cmd_ready, resp_valid, busy, EscreveReg} !== 4'b0010)
      $display("FAIL reset_ctrl: {rdy,vld,busy,we}=%b want 0010", {cmd_ready, resp_valid, busy, EscreveReg});
    else n_pass++;
    n_total++;
    if (resp_data !== 8'd0) $display("FAIL reset_resp_data: got %0d want 0", resp_data);
    else n_pass++;
    n_total++;
    if (resp_erro !== 1'b0) $display("FAIL reset_resp_erro: got %b want 0", resp_erro);
    else n_pass++;
    n_total++;
    if ({regEscrito, regLido, dadoEscrito} !== 12'h000)
      $display("FAIL reset_bank_port: got %h want 000", {regEscrito, regLido, dadoEscrito});
    else n_pass++;
  endtask

  task automatic test_init;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_total++;
      if ({EscreveReg, regEscrito, dadoEscrito, cmd_ready} !== {1'b1, 2'(k), 8'd0, 1'b0})
        $display("FAIL init_write_%0d: we=%b addr=%0d data=%0d rdy=%b want we=1 addr=%0d data=0 rdy=0",
                 k, EscreveReg, regEscrito, dadoEscrito, cmd_ready, k);
      else n_pass++;
    end
    @(negedge clock);
    n_total++;
    if ({cmd_ready, EscreveReg, busy} !== 3'b100)
      $display("FAIL init_done: {rdy,we,busy}=%b want 100", {cmd_ready, EscreveReg, busy});
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (banco[k] !== 8'd0) $display("FAIL init_clear_%0d: reg=%0d want 0", k, banco[k]);
      else n_pass++;
    end
  endtask

  task automatic test_write;
    logic [7:0] rd; logic er, ra; int lat, p0;
    p0 = n_pulsos;
    do_cmd(1'b1, 2'd1, 8'd3, rd, er, lat, ra);
    n_total++;
    if (rd !== 8'd3 || er !== 1'b0) $display("FAIL write_resp: data=%0d erro=%b want 3/0", rd, er);
    else n_pass++;
    n_total++;
    if (lat != LAT_ESC) $display("FAIL write_latency: got %0d want %0d", lat, LAT_ESC);
    else n_pass++;
    n_total++;
    if (n_pulsos - p0 != 1) $display("FAIL write_pulses: got %0d want 1", n_pulsos - p0);
    else n_pass++;
    n_total++;
    if (banco[1] !== 8'd3) $display("FAIL write_bank: reg1=%0d want 3", banco[1]);
    else n_pass++;
    n_total++;
    if (ra !== 1'b1) $display("FAIL write_ready_after: got %b want 1", ra);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [1:0] ad [3];
    logic [7:0] dt [3];
    logic [7:0] rd; logic er, ra; int lat;
    ad = '{2'd3, 2'd1, 2'd2};
    dt = '{8'd12, 8'd10, 8'd11};
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b1, ad[i], dt[i], rd, er, lat, ra);
      n_total++;
      if (rd !== dt[i] || lat != LAT_ESC || ra !== 1'b1)
        $display("FAIL b2b_write_%0d: data=%0d lat=%0d rdy=%b want %0d/%0d/1", i, rd, lat, ra, dt[i], LAT_ESC);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      do_cmd(1'b0, ad[i], 8'hFF, rd, er, lat, ra);
      n_total++;
      if (rd !== dt[i] || er !== 1'b0 || lat != 1 || ra !== 1'b1)
        $display("FAIL b2b_read_%0d: data=%0d erro=%b lat=%0d rdy=%b want %0d/0/1/1", i, rd, er, lat, ra, dt[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int p0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    p0 = n_pulsos;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_data = 8'd99;
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({resp_valid, cmd_ready} !== 2'b10 || resp_data !== 8'd11)
        $display("FAIL stall_%0d: vld=%b rdy=%b data=%0d want 1/0/11", c, resp_valid, cmd_ready, resp_data);
      else n_pass++;
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    n_total++;
    if ({cmd_ready, resp_valid} !== 2'b10) $display("FAIL stall_release: {rdy,vld}=%b want 10", {cmd_ready, resp_valid});
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (n_pulsos != p0 || banco[0] !== 8'd0)
      $display("FAIL stall_no_accept: writes=%0d reg0=%0d want 0/0", n_pulsos - p0, banco[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd0; cmd_data = 8'd7;
    @(negedge clock);
    cmd_valid = 1'b0;
    n_total++;
    if ({EscreveReg, regEscrito, dadoEscrito} !== {1'b1, 2'd0, 8'd7})
      $display("FAIL mid_write_cycle: we=%b addr=%0d data=%0d want 1/0/7", EscreveReg, regEscrito, dadoEscrito);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (EscreveReg !== 1'b0) $display("FAIL mid_abort_we: got %b want 0", EscreveReg);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (escreveu_7_em_0 !== 1'b0 || {busy, cmd_ready, resp_valid} !== 3'b100)
      $display("FAIL mid_reset_state: wrote7=%b {busy,rdy,vld}=%b want 0/100", escreveu_7_em_0, {busy, cmd_ready, resp_valid});
    else n_pass++;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL mid_reinit_ready: got %b want 1", cmd_ready);
    else n_pass++;
    n_total++;
    if ({banco[0], banco[1], banco[2], banco[3]} !== 32'h0 || escreveu_7_em_0 !== 1'b0)
      $display("FAIL mid_reinit_clear: regs=%h wrote7=%b want 0/0", {banco[0], banco[1], banco[2], banco[3]}, escreveu_7_em_0);
    else n_pass++;
  endtask

`ifdef READBACK_CHECK_EN
  task automatic test_readback_error;
    logic [7:0] rd; logic er, ra; int lat;
    forcar_zero = 1'b1;
    do_cmd(1'b1, 2'd2, 8'd5, rd, er, lat, ra);
    forcar_zero = 1'b0;
    n_total++;
    if (er !== 1'b1 || rd !== 8'd0) $display("FAIL readback_err: erro=%b data=%0d want 1/0", er, rd);
    else n_pass++;
    n_total++;
    if (lat != 2 || banco[2] !== 8'd5) $display("FAIL readback_lat: lat=%0d reg2=%0d want 2/5", lat, banco[2]);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_write();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_write();
`ifdef READBACK_CHECK_EN
    test_readback_error();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
